// File: rtl/spi_slave_interface.sv
// SPI mode-0 slave, LSB first, 8-bit bytes, several bytes per cs-low frame, oversampled in the clk domain.
// Define SPI_SLAVE_STATUS_EN to add rx_ack, tx_underrun and rx_overrun.
module spi_slave_interface #(
    parameter int         SYNC_STAGES  = 2,
    parameter logic [7:0] TX_IDLE_BYTE = 8'h00
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       scl,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    input  logic [7:0] tx_byte,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic       busy
`ifdef SPI_SLAVE_STATUS_EN
    ,
    input  logic       rx_ack,
    output logic       tx_underrun,
    output logic       rx_overrun
`endif
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_scl_last;
    logic                   r_cs_last;

    logic       w_scl_s;
    logic       w_cs_s;
    logic       w_mosi_s;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_cs_rise;
    logic       w_cs_fall;

    logic       w_byte_start;
    logic       w_do_rise;
    logic       w_do_fall;
    logic       w_go_idle;
    logic       w_load_ok;
    logic [7:0] w_start_byte;

    logic [2:0] r_bit_cnt;
    logic [7:0] r_rx_shift;
    logic [7:0] r_rx_byte;
    logic       r_rx_done;
    logic       r_rx_valid;
    logic [7:0] r_tx_shift;
    logic [7:0] r_tx_hold;
    logic       r_tx_ready;
    logic       r_miso;
    logic       r_busy;

    // Input synchronizers plus one delayed copy of scl/cs for edge detection
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_scl_sync  <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_scl_last  <= 1'b0;
            r_cs_last   <= 1'b0;
        end else begin
            r_scl_sync  <= {r_scl_sync[SYNC_STAGES-2:0], scl};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_scl_last  <= r_scl_sync[SYNC_STAGES-1];
            r_cs_last   <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    assign w_scl_s    = r_scl_sync[SYNC_STAGES-1];
    assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl_s & ~r_scl_last;
    assign w_scl_fall = ~w_scl_s & r_scl_last;
    assign w_cs_rise  = w_cs_s & ~r_cs_last;
    assign w_cs_fall  = ~w_cs_s & r_cs_last;

    assign w_load_ok    = tx_load & r_tx_ready;
    assign w_start_byte = r_tx_ready ? TX_IDLE_BYTE : r_tx_hold;

    // Frame state register
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle action strobes; cs deassertion outranks any scl edge
    always_comb begin
        w_state_nxt  = r_state;
        w_byte_start = 1'b0;
        w_do_rise    = 1'b0;
        w_do_fall    = 1'b0;
        w_go_idle    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt  = ST_ACTIVE;
                    w_byte_start = 1'b1;
                end else begin
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_go_idle   = 1'b1;
                end else if (w_scl_rise) begin
                    w_do_rise = 1'b1;
                end else if (w_scl_fall) begin
                    if (r_bit_cnt == 3'd0) begin
                        w_byte_start = 1'b1;
                    end else begin
                        w_do_fall = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bit counter, shift registers, miso and received-byte delivery
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_bit_cnt  <= 3'd0;
            r_rx_shift <= 8'h00;
            r_rx_byte  <= 8'h00;
            r_rx_done  <= 1'b0;
            r_rx_valid <= 1'b0;
            r_tx_shift <= 8'h00;
            r_miso     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rx_done  <= 1'b0;
            r_rx_valid <= r_rx_done;
            r_busy     <= (w_state_nxt == ST_ACTIVE);
            if (r_rx_done) begin
                r_rx_byte <= r_rx_shift;
            end
            if (w_go_idle) begin
                r_miso    <= 1'b0;
                r_bit_cnt <= 3'd0;
            end else if (w_do_rise) begin
                r_rx_shift[r_bit_cnt] <= w_mosi_s;
                r_bit_cnt             <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_rx_done <= 1'b1;
                end
            end else if (w_do_fall) begin
                r_miso <= r_tx_shift[r_bit_cnt];
            end else if (w_byte_start) begin
                r_tx_shift <= w_start_byte;
                r_miso     <= w_start_byte[0];
                r_bit_cnt  <= 3'd0;
            end
        end
    end

    // Holding register: a load in the byte-start cycle is kept for the following byte
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_tx_hold  <= 8'h00;
            r_tx_ready <= 1'b1;
        end else if (w_load_ok) begin
            r_tx_hold  <= tx_byte;
            r_tx_ready <= 1'b0;
        end else if (w_byte_start) begin
            r_tx_ready <= 1'b1;
        end
    end

    assign miso     = r_miso;
    assign rx_byte  = r_rx_byte;
    assign rx_valid = r_rx_valid;
    assign tx_ready = r_tx_ready;
    assign busy     = r_busy;

`ifdef SPI_SLAVE_STATUS_EN
    logic r_rx_unacked;
    logic r_tx_underrun;
    logic r_rx_overrun;

    // Status pulses; r_rx_done leads rx_valid by one cycle so the overrun pulse lines up with it
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_rx_unacked  <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_rx_overrun  <= 1'b0;
        end else begin
            r_tx_underrun <= w_byte_start & r_tx_ready;
            r_rx_overrun  <= r_rx_done & r_rx_unacked & ~rx_ack;
            if (r_rx_done) begin
                r_rx_unacked <= 1'b1;
            end else if (rx_ack) begin
                r_rx_unacked <= 1'b0;
            end
        end
    end

    assign tx_underrun = r_tx_underrun;
    assign rx_overrun  = r_rx_overrun;
`endif

endmodule

// File: tb/tb_spi_slave_interface.sv
// Self-checking bench for spi_slave_interface: a mode-0 LSB-first master model plus rx/tx scoreboards.
`timescale 1ns/1ps
module tb_spi_slave_interface;

    localparam int SYNC = 2;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       arst;
    logic       scl;
    logic       cs;
    logic       mosi;
    logic       miso;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] tx_byte;
    logic       tx_load;
    logic       tx_ready;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] rx_got[$];
    logic [7:0] rx_exp[$];
    logic [7:0] tx_exp[$];
    logic [7:0] m_tx[4];
    logic [7:0] m_rx[4];
    logic       busy_seen_low;

    always #5 clk = ~clk;

    spi_slave_interface #(
        .SYNC_STAGES (SYNC),
        .TX_IDLE_BYTE(8'h00)
    ) dut (
        .clk     (clk),
        .arst    (arst),
        .scl     (scl),
        .cs      (cs),
        .mosi    (mosi),
        .miso    (miso),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .tx_byte (tx_byte),
        .tx_load (tx_load),
        .tx_ready(tx_ready),
        .busy    (busy)
    );

    always @(negedge clk) begin
        if (rx_valid === 1'b1) rx_got.push_back(rx_byte);
    end

    // Master: one cs-low frame of nbits bits from m_tx, miso captured into m_rx at each rise.
    task automatic spi_frame(input int nbits, input logic ld_en, input logic [7:0] ld_val);
        int       bi;
        logic [2:0] bb;
        @(negedge clk);
        cs = 1'b0;
        mosi = m_tx[0][0];
        busy_seen_low = 1'b0;
        repeat (SYNC) @(negedge clk);
        if (ld_en) begin
            tx_byte = ld_val;
            tx_load = 1'b1;
            @(negedge clk);
            tx_load = 1'b0;
        end else begin
            @(negedge clk);
        end
        repeat (HALF - SYNC - 1) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            bi = i / 8;
            bb = 3'(i % 8);
            scl = 1'b1;
            m_rx[bi][bb] = miso;
            if (busy !== 1'b1) busy_seen_low = 1'b1;
            repeat (HALF) @(negedge clk);
            scl = 1'b0;
            if (i + 1 < nbits) begin
                bi = (i + 1) / 8;
                bb = 3'((i + 1) % 8);
                mosi = m_tx[bi][bb];
            end
            repeat (HALF) @(negedge clk);
        end
        cs = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic test_reset();
        arst = 1'b1; scl = 1'b0; cs = 1'b1; mosi = 1'b0; tx_load = 1'b0; tx_byte = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++; if (miso !== 1'b0) $display("FAIL reset_miso: got %b want 0", miso); else n_pass++;
        n_checks++; if (rx_byte !== 8'h00) $display("FAIL reset_rx_byte: got %h want 00", rx_byte); else n_pass++;
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b want 0", rx_valid); else n_pass++;
        n_checks++; if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready: got %b want 1", tx_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        arst = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy_after: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_rx_multi();
        logic [7:0] e, g;
        for (int k = 0; k < 4; k++) begin
            m_tx[k] = 8'(k + 1);
            rx_exp.push_back(8'(k + 1));
            tx_exp.push_back(8'h00);
        end
        spi_frame(32, 1'b0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            e = rx_exp.pop_front();
            n_checks++;
            if (rx_got.size() == 0) $display("FAIL rx_multi_%0d: got nothing want %h", k, e);
            else begin
                g = rx_got.pop_front();
                if (g !== e) $display("FAIL rx_multi_%0d: got %h want %h", k, g, e); else n_pass++;
            end
            e = tx_exp.pop_front();
            n_checks++; if (m_rx[k] !== e) $display("FAIL rx_multi_miso_%0d: got %h want %h", k, m_rx[k], e); else n_pass++;
        end
        n_checks++; if (busy_seen_low !== 1'b0) $display("FAIL rx_multi_busy: got dropped want held 1"); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rx_multi_busy_end: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_tx_stage();
        logic [7:0] e, g;
        int         t;
        @(negedge clk);
        tx_byte = 8'd45; tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        n_checks++; if (tx_ready !== 1'b0) $display("FAIL tx_stage_ready0: got %b want 0", tx_ready); else n_pass++;
        m_tx[0] = 8'hA5; m_tx[1] = 8'h3C;
        rx_exp.push_back(8'hA5); rx_exp.push_back(8'h3C);
        tx_exp.push_back(8'd45); tx_exp.push_back(8'd53);
        fork
            spi_frame(16, 1'b0, 8'h00);
            begin
                t = 0;
                while (tx_ready !== 1'b1 && t < 400) begin @(negedge clk); t++; end
                n_checks++;
                if (t >= 400) $display("FAIL tx_stage_wait_ready: got timeout want tx_ready=1");
                else begin
                    n_pass++;
                    tx_byte = 8'd53; tx_load = 1'b1;
                    @(negedge clk);
                    tx_load = 1'b0;
                    n_checks++; if (tx_ready !== 1'b0) $display("FAIL tx_stage_ready1: got %b want 0", tx_ready); else n_pass++;
                end
            end
        join
        for (int k = 0; k < 2; k++) begin
            e = tx_exp.pop_front();
            n_checks++; if (m_rx[k] !== e) $display("FAIL tx_stage_miso_%0d: got %0d want %0d", k, m_rx[k], e); else n_pass++;
            e = rx_exp.pop_front();
            n_checks++;
            if (rx_got.size() == 0) $display("FAIL tx_stage_rx_%0d: got nothing want %h", k, e);
            else begin
                g = rx_got.pop_front();
                if (g !== e) $display("FAIL tx_stage_rx_%0d: got %h want %h", k, g, e); else n_pass++;
            end
        end
        n_checks++; if (tx_ready !== 1'b1) $display("FAIL tx_stage_ready_end: got %b want 1", tx_ready); else n_pass++;
    endtask

    task automatic test_idle_byte();
        logic [7:0] e;
        m_tx[0] = 8'h5A; m_tx[1] = 8'h96;
        tx_exp.push_back(8'h00); tx_exp.push_back(8'h00);
        spi_frame(16, 1'b0, 8'h00);
        for (int k = 0; k < 2; k++) begin
            e = tx_exp.pop_front();
            n_checks++; if (m_rx[k] !== e) $display("FAIL idle_miso_%0d: got %h want %h", k, m_rx[k], e); else n_pass++;
        end
        n_checks++; if (rx_got.size() != 2) $display("FAIL idle_rx_count: got %0d want 2", rx_got.size()); else n_pass++;
        rx_got.delete();
    endtask

    task automatic test_partial();
        logic [7:0] e, g;
        m_tx[0] = 8'hFF;
        spi_frame(5, 1'b0, 8'h00);
        n_checks++; if (rx_got.size() != 0) $display("FAIL partial_no_valid: got %0d pulses want 0", rx_got.size()); else n_pass++;
        n_checks++; if (rx_byte !== 8'h96) $display("FAIL partial_rx_hold: got %h want 96", rx_byte); else n_pass++;
        rx_got.delete();
        m_tx[0] = 8'd11;
        rx_exp.push_back(8'd11);
        spi_frame(8, 1'b0, 8'h00);
        e = rx_exp.pop_front();
        n_checks++;
        if (rx_got.size() != 1) $display("FAIL partial_next: got %0d bytes want 1 (%0d)", rx_got.size(), e);
        else begin
            g = rx_got.pop_front();
            if (g !== e) $display("FAIL partial_next: got %0d want %0d", g, e); else n_pass++;
        end
        rx_got.delete();
    endtask

    task automatic test_arst_mid();
        logic [7:0] e, g;
        @(negedge clk);
        tx_byte = 8'hFF; tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        cs = 1'b0; mosi = 1'b1;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            scl = 1'b1; repeat (HALF) @(negedge clk);
            scl = 1'b0; repeat (HALF) @(negedge clk);
        end
        scl = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (miso !== 1'b1) $display("FAIL arst_pre_miso: got %b want 1", miso); else n_pass++;
        #2 arst = 1'b1;
        #1;
        n_checks++; if (miso !== 1'b0) $display("FAIL arst_miso: got %b want 0", miso); else n_pass++;
        n_checks++; if (tx_ready !== 1'b1) $display("FAIL arst_tx_ready: got %b want 1", tx_ready); else n_pass++;
        n_checks++; if (rx_byte !== 8'h00) $display("FAIL arst_rx_byte: got %h want 00", rx_byte); else n_pass++;
        @(negedge clk);
        arst = 1'b0; scl = 1'b0; cs = 1'b1;
        repeat (HALF) @(negedge clk);
        n_checks++; if (rx_got.size() != 0) $display("FAIL arst_no_valid: got %0d pulses want 0", rx_got.size()); else n_pass++;
        rx_got.delete();
        m_tx[0] = 8'd21;
        rx_exp.push_back(8'd21);
        spi_frame(8, 1'b0, 8'h00);
        e = rx_exp.pop_front();
        n_checks++;
        if (rx_got.size() != 1) $display("FAIL arst_next: got %0d bytes want 1 (%0d)", rx_got.size(), e);
        else begin
            g = rx_got.pop_front();
            if (g !== e) $display("FAIL arst_next: got %0d want %0d", g, e); else n_pass++;
        end
        n_checks++; if (m_rx[0] !== 8'h00) $display("FAIL arst_next_miso: got %h want 00", m_rx[0]); else n_pass++;
        rx_got.delete();
    endtask

    task automatic test_same_cycle_load();
        logic [7:0] e;
        n_checks++; if (tx_ready !== 1'b1) $display("FAIL same_cycle_empty: got %b want 1", tx_ready); else n_pass++;
        m_tx[0] = 8'h33; m_tx[1] = 8'h44;
        tx_exp.push_back(8'h00); tx_exp.push_back(8'd31);
        spi_frame(16, 1'b1, 8'd31);
        for (int k = 0; k < 2; k++) begin
            e = tx_exp.pop_front();
            n_checks++; if (m_rx[k] !== e) $display("FAIL same_cycle_miso_%0d: got %0d want %0d", k, m_rx[k], e); else n_pass++;
        end
        n_checks++; if (tx_ready !== 1'b1) $display("FAIL same_cycle_ready_end: got %b want 1", tx_ready); else n_pass++;
        rx_got.delete();
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_rx_multi();
        test_tx_stage();
        test_idle_byte();
        test_partial();
        test_arst_mid();
        test_same_cycle_load();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
